// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
// Holds the opcode constants, the flag bit indices into the 5-bit
// {Z,C,F,N,L} flag vector, and the sequencer state encoding.
package alu_pkg;

  // Single-cycle opcodes
  localparam logic [7:0] OP_AND   = 8'h01;
  localparam logic [7:0] OP_OR    = 8'h02;
  localparam logic [7:0] OP_XOR   = 8'h03;
  localparam logic [7:0] OP_NOT   = 8'h04;
  localparam logic [7:0] OP_ADD   = 8'h05;
  localparam logic [7:0] OP_SUB   = 8'h06;
  localparam logic [7:0] OP_ADDU  = 8'h07;
  localparam logic [7:0] OP_ADDC  = 8'h08;
  localparam logic [7:0] OP_ADDCU = 8'h09;
  localparam logic [7:0] OP_CMP   = 8'h0B;
  localparam logic [7:0] OP_CMPU  = 8'h0F;

  // Multi-cycle opcodes
  localparam logic [7:0] OP_MUL   = 8'h0E;
  localparam logic [7:0] OP_LSH   = 8'h84;
  localparam logic [7:0] OP_ARSH  = 8'h86;

  // Flag indices within {Z,C,F,N,L}
  localparam int unsigned FLAG_Z = 4;
  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_L = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [7:0] op);
    return (op == OP_LSH) || (op == OP_ARSH);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle datapath and flag generation.
// Ports:
//   op_i     opcode
//   a_i,b_i  operands
//   flags_i  current status flags (carry-in for ADDC/ADDCU, NOP passthrough)
//   res_o    result
//   flags_o  {Z,C,F,N,L} for this result
// Opcodes not handled here produce the NOP response: res_o=0, flags_o=flags_i.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [7:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       flags_i,
  output logic [WIDTH-1:0] res_o,
  output logic [4:0]       flags_o
);

  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;

  always_comb begin
    cin  = ((op_i == OP_ADDC) || (op_i == OP_ADDCU)) ? flags_i[FLAG_C] : 1'b0;
    sum  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin};
    diff = a_i - b_i;

    res_o   = '0;
    flags_o = flags_i;

    case (op_i)
      OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        case (op_i)
          OP_AND:  res_o = a_i & b_i;
          OP_OR:   res_o = a_i | b_i;
          OP_XOR:  res_o = a_i ^ b_i;
          default: res_o = ~a_i;
        endcase
        flags_o         = '0;
        flags_o[FLAG_Z] = (res_o == '0);
      end
      OP_ADD, OP_ADDC: begin
        res_o           = sum[WIDTH-1:0];
        flags_o         = '0;
        flags_o[FLAG_Z] = (res_o == '0);
        // signed overflow: like-signed operands giving an opposite-signed sum
        flags_o[FLAG_F] = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res_o[WIDTH-1] != a_i[WIDTH-1]);
        flags_o[FLAG_N] = res_o[WIDTH-1];
      end
      OP_SUB: begin
        res_o           = diff;
        flags_o         = '0;
        flags_o[FLAG_Z] = (res_o == '0);
        flags_o[FLAG_F] = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res_o[WIDTH-1] != a_i[WIDTH-1]);
        flags_o[FLAG_N] = res_o[WIDTH-1];
      end
      OP_ADDU, OP_ADDCU: begin
        res_o           = sum[WIDTH-1:0];
        flags_o         = '0;
        flags_o[FLAG_Z] = (res_o == '0);
        flags_o[FLAG_C] = sum[WIDTH];
      end
      OP_CMP: begin
        flags_o         = '0;
        flags_o[FLAG_Z] = (a_i == b_i);
        flags_o[FLAG_N] = ($signed(a_i) < $signed(b_i));
      end
      OP_CMPU: begin
        flags_o         = '0;
        flags_o[FLAG_Z] = (a_i == b_i);
        flags_o[FLAG_L] = (a_i < b_i);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a one-entry result register.
// Single-cycle ops come from alu_comb; shifts (one bit per cycle) and the
// optional shift-add multiplier are sequenced here.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     request handshake; in_op, in_a, in_b request payload
//   out_valid/out_ready   result handshake; out_data, out_flags result payload
//   flags                 live status flags {Z,C,F,N,L}
//   busy                  multi-cycle operation in progress
// Configuration macro: ALU_SEQ_MUL_EN enables opcode 0x0E (MUL); when
// undefined 0x0E is a NOP and no multiplier hardware is built.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_flags,
  output logic [4:0]       flags,
  output logic             busy
);

  // Shift amount is the signed field B[log2(WIDTH):0]; its magnitude can
  // never exceed WIDTH, so the clamp to WIDTH is implicit in this width.
  localparam int unsigned AW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [4:0]       out_flags_q, out_flags_d;
  logic [4:0]       flags_q, flags_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [AW-1:0]    sh_cnt_q, sh_cnt_d;
  logic             sh_left_q, sh_left_d;
  logic             sh_arith_q, sh_arith_d;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0]   mp_q, mp_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_n;
  logic [AW-1:0]      mul_cnt_q, mul_cnt_d;
`endif

  logic             accept;
  logic [AW-1:0]    sh_amt, sh_mag;
  logic             sh_neg;
  logic [WIDTH:0]   sh_first, sh_step;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [4:0]       wr_flags;
  logic [WIDTH-1:0] comb_res;
  logic [4:0]       comb_flags;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op_i    (in_op),
    .a_i     (in_a),
    .b_i     (in_b),
    .flags_i (flags_q),
    .res_o   (comb_res),
    .flags_o (comb_flags)
  );

  // One-bit shift; returns {bit shifted out, shifted value}.
  function automatic logic [WIDTH:0] shift1(input logic [WIDTH-1:0] v,
                                            input logic left, input logic arith);
    if (left) return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
    else      return {v[0], (arith ? v[WIDTH-1] : 1'b0), v[WIDTH-1:1]};
  endfunction

  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;
  assign flags     = flags_q;

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    sh_cnt_d   = sh_cnt_q;
    sh_left_d  = sh_left_q;
    sh_arith_d = sh_arith_q;
    wr_en      = 1'b0;
    wr_data    = '0;
    wr_flags   = '0;
`ifdef ALU_SEQ_MUL_EN
    mc_d      = mc_q;
    mp_d      = mp_q;
    prod_d    = prod_q;
    mul_cnt_d = mul_cnt_q;
    prod_n    = mp_q[0] ? (prod_q + mc_q) : prod_q;
`endif

    sh_amt   = in_b[AW-1:0];
    sh_neg   = sh_amt[AW-1];
    sh_mag   = sh_neg ? -sh_amt : sh_amt;
    sh_first = shift1(in_a, !sh_neg, (in_op == OP_ARSH));
    sh_step  = shift1(sh_q, sh_left_q, sh_arith_q);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift_op(in_op)) begin
            // The first bit moves in the accept cycle, so an n-bit shift
            // presents its result n cycles after acceptance; n<=1 never
            // needs the SHIFT state.
            if (sh_mag == '0) begin
              wr_en            = 1'b1;
              wr_data          = in_a;
              wr_flags[FLAG_Z] = (in_a == '0);
            end else if (sh_mag == AW'(1)) begin
              wr_en            = 1'b1;
              wr_data          = sh_first[WIDTH-1:0];
              wr_flags[FLAG_Z] = (sh_first[WIDTH-1:0] == '0);
              wr_flags[FLAG_C] = sh_first[WIDTH];
            end else begin
              state_d    = ST_SHIFT;
              sh_d       = sh_first[WIDTH-1:0];
              sh_cnt_d   = sh_mag - AW'(1);
              sh_left_d  = !sh_neg;
              sh_arith_d = (in_op == OP_ARSH);
            end
          end
`ifdef ALU_SEQ_MUL_EN
          else if (in_op == OP_MUL) begin
            state_d   = ST_MUL;
            mc_d      = {{WIDTH{1'b0}}, in_a};
            mp_d      = in_b;
            prod_d    = '0;
            mul_cnt_d = AW'(WIDTH);
          end
`endif
          else begin
            wr_en    = 1'b1;
            wr_data  = comb_res;
            wr_flags = comb_flags;
          end
        end
      end
      ST_SHIFT: begin
        sh_d     = sh_step[WIDTH-1:0];
        sh_cnt_d = sh_cnt_q - AW'(1);
        if (sh_cnt_q == AW'(1)) begin
          state_d          = ST_IDLE;
          wr_en            = 1'b1;
          wr_data          = sh_step[WIDTH-1:0];
          wr_flags[FLAG_Z] = (sh_step[WIDTH-1:0] == '0);
          wr_flags[FLAG_C] = sh_step[WIDTH];
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        prod_d    = prod_n;
        mc_d      = mc_q << 1;
        mp_d      = mp_q >> 1;
        mul_cnt_d = mul_cnt_q - AW'(1);
        if (mul_cnt_q == AW'(1)) begin
          state_d          = ST_IDLE;
          wr_en            = 1'b1;
          wr_data          = prod_n[WIDTH-1:0];
          wr_flags[FLAG_Z] = (prod_n[WIDTH-1:0] == '0);
          wr_flags[FLAG_C] = (prod_n[2*WIDTH-1:WIDTH] != '0);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    out_valid_d = wr_en ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_data_d  = wr_en ? wr_data  : out_data_q;
    out_flags_d = wr_en ? wr_flags : out_flags_q;
    flags_d     = wr_en ? wr_flags : flags_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
      flags_q     <= '0;
      sh_q        <= '0;
      sh_cnt_q    <= '0;
      sh_left_q   <= 1'b0;
      sh_arith_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mc_q        <= '0;
      mp_q        <= '0;
      prod_q      <= '0;
      mul_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
      flags_q     <= flags_d;
      sh_q        <= sh_d;
      sh_cnt_q    <= sh_cnt_d;
      sh_left_q   <= sh_left_d;
      sh_arith_q  <= sh_arith_d;
`ifdef ALU_SEQ_MUL_EN
      mc_q        <= mc_d;
      mp_q        <= mp_d;
      prod_q      <= prod_d;
      mul_cnt_q   <= mul_cnt_d;
`endif
    end
  end

endmodule
